ifetch: RTL and testbench

Instruction fetch stage of the five-stage pipeline. Holds the program counter, drives the instruction memory address, and registers the fetched word, its PC and a halt flag into the IF/ID pipeline register. That register feeds the decode stage's `instr_in_id`, `pc_in_id` and `halt_in_id` inputs. The block applies stalls from the hazard unit, redirects from execute (taken branch, JAL, JALR) and the global halt, and inserts NOP bubbles where required.

---
 rtl/ifetch.sv | 111 +++++++++++
 tb/tb_ifetch.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// Instruction fetch stage: owns the program counter, addresses instruction memory
// and fills the IF/ID register with the fetched word, its PC, a fault flag and a valid bit.
module ifetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in_if,
    input  logic        redirect_in_if,
    input  logic [31:0] redirect_pc_in_if,
    input  logic        halt_in_if,
    output logic [31:0] imem_addr_out_if,
    input  logic [31:0] imem_data_in_if,
    output logic [31:0] instr_out_if,
    output logic [31:0] pc_out_if,
    output logic        halt_out_if,
    output logic        valid_out_if,
    output logic [31:0] fetch_count_out_if
);

    typedef enum logic {
        RUN,
        HALTED
    } fsmState_t;

    fsmState_t   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ifPc_q, ifPc_d;
    logic        halt_q, halt_d;
    logic        valid_q, valid_d;
    logic [31:0] count_q, count_d;
    logic        misaligned;

    // A redirect may leave a misaligned PC; the fault is only detected when fetching from it.
    assign misaligned = (pc_q[1:0] != 2'b00);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ifPc_d  = ifPc_q;
        halt_d  = halt_q;
        valid_d = valid_q;
        count_d = count_q;
        case (state_q)
            RUN: begin
                if (halt_in_if) begin
                    state_d = HALTED;
                    instr_d = NOP_INSTR;
                    ifPc_d  = pc_q;
                    halt_d  = 1'b0;
                    valid_d = 1'b0;
                end else if (redirect_in_if) begin
                    pc_d    = redirect_pc_in_if;
                    instr_d = NOP_INSTR;
                    ifPc_d  = pc_q;
                    halt_d  = 1'b0;
                    valid_d = 1'b0;
                end else if (misaligned) begin
                    state_d = HALTED;
                    instr_d = NOP_INSTR;
                    ifPc_d  = pc_q;
                    halt_d  = 1'b1;
                    valid_d = 1'b0;
                end else if (!stall_in_if) begin
                    pc_d    = pc_q + 32'd4;
                    instr_d = imem_data_in_if;
                    ifPc_d  = pc_q;
                    halt_d  = 1'b0;
                    valid_d = 1'b1;
                    count_d = count_q + 32'd1;
                end
            end
            HALTED: begin
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            ifPc_q  <= RESET_PC;
            halt_q  <= 1'b0;
            valid_q <= 1'b0;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ifPc_q  <= ifPc_d;
            halt_q  <= halt_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign imem_addr_out_if   = pc_q;
    assign instr_out_if       = instr_q;
    assign pc_out_if          = ifPc_q;
    assign halt_out_if        = halt_q;
    assign valid_out_if       = valid_q;
    assign fetch_count_out_if = count_q;

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: a vector table drives one edge per row, expected
// IF/ID contents go through a scoreboard queue; hand-written sequences cover reset corners.
module tb_ifetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirPc = 32'd0;
    logic        haltIn = 1'b0;
    logic [31:0] imemAddr, imemData, instrOut, pcOut, countOut;
    logic        haltOut, validOut;

    logic [31:0] imemAddr2, imemData2, instrOut2, pcOut2, countOut2;
    logic        haltOut2, validOut2;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'h1234_5600;
    endfunction

    assign imemData  = memWord(imemAddr);
    assign imemData2 = memWord(imemAddr2);

    ifetch dut (
        .clk                (clk),
        .rst                (rst),
        .stall_in_if        (stall),
        .redirect_in_if     (redirect),
        .redirect_pc_in_if  (redirPc),
        .halt_in_if         (haltIn),
        .imem_addr_out_if   (imemAddr),
        .imem_data_in_if    (imemData),
        .instr_out_if       (instrOut),
        .pc_out_if          (pcOut),
        .halt_out_if        (haltOut),
        .valid_out_if       (validOut),
        .fetch_count_out_if (countOut)
    );

    // Second instance starts near the top of the address space to exercise PC wrap.
    ifetch #(.RESET_PC(32'hFFFF_FFF8)) dutWrap (
        .clk                (clk),
        .rst                (rst),
        .stall_in_if        (1'b0),
        .redirect_in_if     (1'b0),
        .redirect_pc_in_if  (32'd0),
        .halt_in_if         (1'b0),
        .imem_addr_out_if   (imemAddr2),
        .imem_data_in_if    (imemData2),
        .instr_out_if       (instrOut2),
        .pc_out_if          (pcOut2),
        .halt_out_if        (haltOut2),
        .valid_out_if       (validOut2),
        .fetch_count_out_if (countOut2)
    );

    typedef struct {
        logic        rstBefore;
        logic        stall;
        logic        redirect;
        logic [31:0] redirPc;
        logic        haltIn;
        logic [31:0] expInstr;
        logic [31:0] expPc;
        logic        chkPc;
        logic        expHalt;
        logic        expValid;
        logic [31:0] expCount;
        logic [31:0] expAddr;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        chkPc;
        logic        halt;
        logic        valid;
        logic [31:0] count;
        logic [31:0] addr;
    } exp_t;

    exp_t sbQ[$];
    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mkVec(input logic r, input logic s, input logic rd,
                                   input logic [31:0] rp, input logic h,
                                   input logic [31:0] ei, input logic [31:0] ep,
                                   input logic cp, input logic eh, input logic ev,
                                   input logic [31:0] ec, input logic [31:0] ea);
        vec_t v;
        v.rstBefore = r;  v.stall = s;     v.redirect = rd; v.redirPc = rp;
        v.haltIn = h;     v.expInstr = ei; v.expPc = ep;    v.chkPc = cp;
        v.expHalt = eh;   v.expValid = ev; v.expCount = ec; v.expAddr = ea;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        check({tag, ".instr"}, instrOut, NOP);
        check({tag, ".pc"}, pcOut, 32'd0);
        check({tag, ".halt"}, {31'b0, haltOut}, 32'd0);
        check({tag, ".valid"}, {31'b0, validOut}, 32'd0);
        check({tag, ".count"}, countOut, 32'd0);
        check({tag, ".addr"}, imemAddr, 32'd0);
    endtask

    task automatic checkOutput(input int idx);
        exp_t e;
        if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard row %0d: got empty queue expected an entry", idx);
            return;
        end
        e = sbQ.pop_front();
        check($sformatf("r%0d.instr", idx), instrOut, e.instr);
        if (e.chkPc) check($sformatf("r%0d.pc", idx), pcOut, e.pc);
        check($sformatf("r%0d.halt", idx), {31'b0, haltOut}, {31'b0, e.halt});
        check($sformatf("r%0d.valid", idx), {31'b0, validOut}, {31'b0, e.valid});
        check($sformatf("r%0d.count", idx), countOut, e.count);
        check($sformatf("r%0d.addr", idx), imemAddr, e.addr);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        exp_t e;
        @(negedge clk);
        if (v.rstBefore) begin
            rst = 1'b1; stall = 1'b0; redirect = 1'b0; haltIn = 1'b0;
            #1;
            checkReset($sformatf("r%0d.reset", idx));
            #1 rst = 1'b0;
        end
        stall    = v.stall;
        redirect = v.redirect;
        redirPc  = v.redirPc;
        haltIn   = v.haltIn;
        e.instr = v.expInstr; e.pc = v.expPc; e.chkPc = v.chkPc; e.halt = v.expHalt;
        e.valid = v.expValid; e.count = v.expCount; e.addr = v.expAddr;
        sbQ.push_back(e);
        @(posedge clk);
        #1;
        checkOutput(idx);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0] wrapPcs[3];
        vec_t        v;
        int          n;
        wrapPcs = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

        // sequential fetch
        vecs.push_back(mkVec(1, 0, 0, 0, 0, memWord(0), 0, 1, 0, 1, 1, 32'h4));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, memWord(4), 4, 1, 0, 1, 2, 32'h8));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, memWord(8), 8, 1, 0, 1, 3, 32'hC));
        // stall two cycles on B, then redirect under stall, then halt at 0x10
        vecs.push_back(mkVec(1, 0, 0, 0, 0, memWord(0), 0, 1, 0, 1, 1, 32'h4));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, memWord(4), 4, 1, 0, 1, 2, 32'h8));
        vecs.push_back(mkVec(0, 1, 0, 0, 0, memWord(4), 4, 1, 0, 1, 2, 32'h8));
        vecs.push_back(mkVec(0, 1, 0, 0, 0, memWord(4), 4, 1, 0, 1, 2, 32'h8));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, memWord(8), 8, 1, 0, 1, 3, 32'hC));
        vecs.push_back(mkVec(0, 1, 1, 32'h40, 0, NOP, 0, 0, 0, 0, 3, 32'h40));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, memWord(32'h40), 32'h40, 1, 0, 1, 4, 32'h44));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, memWord(32'h44), 32'h44, 1, 0, 1, 5, 32'h48));
        vecs.push_back(mkVec(0, 0, 1, 32'h10, 0, NOP, 0, 0, 0, 0, 5, 32'h10));
        vecs.push_back(mkVec(0, 0, 0, 0, 1, NOP, 0, 0, 0, 0, 5, 32'h10));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, NOP, 0, 0, 0, 0, 5, 32'h10));
        vecs.push_back(mkVec(0, 1, 1, 32'h80, 0, NOP, 0, 0, 0, 0, 5, 32'h10));
        // misaligned redirect: bubble, then fault slot
        vecs.push_back(mkVec(1, 0, 0, 0, 0, memWord(0), 0, 1, 0, 1, 1, 32'h4));
        vecs.push_back(mkVec(0, 0, 1, 32'h42, 0, NOP, 0, 0, 0, 0, 1, 32'h42));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, NOP, 32'h42, 1, 1, 0, 1, 32'h42));

        n = 0;
        foreach (vecs[i]) begin
            applyStimulus(vecs[i], n);
            n++;
        end

        // HALTED after the fault: everything frozen despite redirects and stalls
        for (int i = 0; i < 10; i++) begin
            v = mkVec(0, 1'($urandom_range(1)), 1, $urandom & 32'hFFFF_FFFC, 0,
                      NOP, 32'h42, 1, 1, 0, 1, 32'h42);
            applyStimulus(v, n);
            n++;
        end

        // asynchronous reset in the middle of a stall
        applyStimulus(mkVec(1, 0, 0, 0, 0, memWord(0), 0, 1, 0, 1, 1, 32'h4), n);
        n++;
        @(negedge clk);
        stall = 1'b1; redirect = 1'b0; haltIn = 1'b0;
        @(posedge clk);
        #1;
        check("stallHold.instr", instrOut, memWord(0));
        check("stallHold.count", countOut, 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkReset("midStallReset");
        check("wrapReset.pc", pcOut2, 32'hFFFF_FFF8);
        check("wrapReset.addr", imemAddr2, 32'hFFFF_FFF8);
        rst = 1'b0;
        stall = 1'b0;

        // PC wrap from the top of the address space without a fault
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("wrap%0d.pc", i), pcOut2, wrapPcs[i]);
            check($sformatf("wrap%0d.instr", i), instrOut2, memWord(wrapPcs[i]));
            check($sformatf("wrap%0d.valid", i), {31'b0, validOut2}, 32'd1);
            check($sformatf("wrap%0d.halt", i), {31'b0, haltOut2}, 32'd0);
            check($sformatf("wrap%0d.count", i), countOut2, 32'(i + 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
